// File: rtl/pbs_turn_ctrl.sv
// Battle-round sequencer: player attack then AI attack, with LFSR-driven hit rolls and AI move choice.
// Owns both HP registers; damage/accuracy come combinationally from the external move table.
module pbs_turn_ctrl #(
  parameter int         HP_W       = 4,
  parameter int         P_HP_INIT  = 10,
  parameter int         AI_HP_INIT = 10,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic [1:0]      p_move,
  input  logic [HP_W-1:0] p_dmg,
  input  logic [HP_W-1:0] p_accu,
  input  logic [HP_W-1:0] ai_dmg,
  input  logic [HP_W-1:0] ai_accu,
  output logic [1:0]      p_move_q,
  output logic [1:0]      ai_move,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            active_trainer,
  output logic            target,
  output logic            busy,
  output logic            last_hit,
  output logic            victory,
  output logic            loss,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P_ROLL   = 3'd1,
    P_APPLY  = 3'd2,
    AI_ROLL  = 3'd3,
    AI_APPLY = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  state_t          st_q, st_d;
  logic            go_q;
  logic [7:0]      lfsr_q;
  logic [7:0]      lfsr_nxt;
  logic [3:0]      rnd;
  logic            start;
  logic            p_hit, ai_hit;
  logic [HP_W-1:0] dmg_p1;
  logic [HP_W-1:0] ai_hp_sub, p_hp_sub;

  // Accuracy of all-ones is an unconditional hit; zero can never beat rnd.
  function automatic logic roll_hit(input logic [HP_W-1:0] accu, input logic [3:0] r);
    roll_hit = (accu == {HP_W{1'b1}}) | (HP_W'(r) < accu);
  endfunction

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [HP_W-1:0] dmg);
    sat_sub = (hp > dmg) ? (hp - dmg) : '0;
  endfunction

  assign start    = go & ~go_q;
  assign lfsr_nxt = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign rnd      = lfsr_q[3:0];
  assign p_hit    = roll_hit(p_accu, rnd);
  assign ai_hit   = roll_hit(ai_accu, rnd);
  assign ai_hp_sub = sat_sub(ai_hp, dmg_p1);
  assign p_hp_sub  = sat_sub(p_hp, dmg_p1);
  assign state    = st_q;

  // State register and control/HP registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= IDLE;
      go_q     <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      p_hp     <= HP_W'(P_HP_INIT);
      ai_hp    <= HP_W'(AI_HP_INIT);
      p_move_q <= 2'd0;
      ai_move  <= 2'd0;
      last_hit <= 1'b0;
    end else begin
      st_q   <= st_d;
      go_q   <= go;
      lfsr_q <= lfsr_nxt;
      unique case (st_q)
        IDLE:     if (start) p_move_q <= p_move;
        P_ROLL:   last_hit <= p_hit;
        P_APPLY: begin
          ai_hp   <= ai_hp_sub;
          ai_move <= lfsr_q[5:4];
        end
        AI_ROLL:  last_hit <= ai_hit;
        AI_APPLY: p_hp <= p_hp_sub;
        default: ;
      endcase
    end
  end

  // Roll stage -> apply stage damage register (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (st_q == P_ROLL) begin
      dmg_p1 <= p_hit ? p_dmg : '0;
    end else if (st_q == AI_ROLL) begin
      dmg_p1 <= ai_hit ? ai_dmg : '0;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:     if (start) st_d = P_ROLL;
      P_ROLL:   st_d = P_APPLY;
      P_APPLY:  st_d = (ai_hp_sub == '0) ? WIN : AI_ROLL;
      AI_ROLL:  st_d = AI_APPLY;
      AI_APPLY: st_d = (p_hp_sub == '0) ? LOSE : IDLE;
      WIN:      st_d = WIN;
      LOSE:     st_d = LOSE;
      default:  st_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = 1'b0;
    active_trainer = 1'b0;
    target         = 1'b0;
    victory        = 1'b0;
    loss           = 1'b0;
    unique case (st_q)
      P_ROLL, P_APPLY: begin
        busy   = 1'b1;
        target = 1'b1;
      end
      AI_ROLL, AI_APPLY: begin
        busy           = 1'b1;
        active_trainer = 1'b1;
      end
      WIN:     victory = 1'b1;
      LOSE:    loss    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Directed bench for pbs_turn_ctrl: drives and samples on the falling edge.
module tb_pbs_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [1:0] p_move;
  logic [3:0] p_dmg, p_accu, ai_dmg, ai_accu;
  logic [1:0] p_move_q, ai_move;
  logic [3:0] p_hp, ai_hp;
  logic       active_trainer, target, busy, last_hit, victory, loss;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_p, exp_ai;
  logic [7:0] lfsr_m;

  always #5 clk = ~clk;

  pbs_turn_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .p_move(p_move),
    .p_dmg(p_dmg), .p_accu(p_accu), .ai_dmg(ai_dmg), .ai_accu(ai_accu),
    .p_move_q(p_move_q), .ai_move(ai_move), .p_hp(p_hp), .ai_hp(ai_hp),
    .active_trainer(active_trainer), .target(target), .busy(busy),
    .last_hit(last_hit), .victory(victory), .loss(loss), .state(state)
  );

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifting left
  always @(posedge clk) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic logic hit_m(input logic [3:0] accu, input logic [3:0] r);
    hit_m = (accu == 4'hF) || (r < accu);
  endfunction

  function automatic logic [3:0] sub_m(input logic [3:0] hp, input logic [3:0] d);
    sub_m = (hp > d) ? hp - d : 4'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
    exp_p = 4'd10;
    exp_ai = 4'd10;
  endtask

  // One round from IDLE; retrig raises a fresh go edge during P_APPLY and leaves go high.
  task automatic round(input logic [3:0] pa, input logic [3:0] pd,
                       input logic [3:0] aa, input logic [3:0] ad,
                       input logic [1:0] mv, input bit retrig);
    logic       h;
    logic [1:0] am;
    p_accu = pa; p_dmg = pd; ai_accu = aa; ai_dmg = ad;
    p_move = mv;
    go = 1'b1;
    @(negedge clk);
    p_move = ~mv;
    if (retrig) go = 1'b0;
    chk("st_p_roll", 32'(state), 1);
    chk("busy_p_roll", 32'(busy), 1);
    chk("target_p", 32'(target), 1);
    chk("active_p", 32'(active_trainer), 0);
    h = hit_m(pa, lfsr_m[3:0]);
    @(negedge clk);
    if (retrig) go = 1'b1;
    chk("st_p_apply", 32'(state), 2);
    chk("hit_player", 32'(last_hit), 32'(h));
    chk("p_move_q", 32'(p_move_q), 32'(mv));
    am = lfsr_m[5:4];
    exp_ai = sub_m(exp_ai, h ? pd : 4'd0);
    @(negedge clk);
    chk("ai_hp_c3", 32'(ai_hp), 32'(exp_ai));
    chk("ai_move", 32'(ai_move), 32'(am));
    chk("p_hp_c3", 32'(p_hp), 32'(exp_p));
    if (exp_ai == 4'd0) begin
      chk("st_win", 32'(state), 5);
      chk("victory", 32'(victory), 1);
      chk("loss_on_win", 32'(loss), 0);
      chk("busy_win", 32'(busy), 0);
      return;
    end
    chk("st_ai_roll", 32'(state), 3);
    chk("active_ai", 32'(active_trainer), 1);
    chk("target_ai", 32'(target), 0);
    h = hit_m(aa, lfsr_m[3:0]);
    @(negedge clk);
    chk("st_ai_apply", 32'(state), 4);
    chk("hit_ai", 32'(last_hit), 32'(h));
    exp_p = sub_m(exp_p, h ? ad : 4'd0);
    @(negedge clk);
    chk("p_hp_c5", 32'(p_hp), 32'(exp_p));
    if (exp_p == 4'd0) begin
      chk("st_lose", 32'(state), 6);
      chk("loss", 32'(loss), 1);
      chk("victory_on_loss", 32'(victory), 0);
    end else begin
      chk("st_idle_c5", 32'(state), 0);
      chk("busy_idle", 32'(busy), 0);
    end
    if (!retrig) go = 1'b0;
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; p_move = 2'd0;
    p_dmg = 4'd0; p_accu = 4'd0; ai_dmg = 4'd0; ai_accu = 4'd0;
    exp_p = 4'd10; exp_ai = 4'd10;
    @(negedge clk);
    do_reset();
    chk("rst_p_hp", 32'(p_hp), 10);
    chk("rst_ai_hp", 32'(ai_hp), 10);
    chk("rst_state", 32'(state), 0);
    chk("rst_victory", 32'(victory), 0);
    chk("rst_loss", 32'(loss), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_last_hit", 32'(last_hit), 0);
    chk("rst_ai_move", 32'(ai_move), 0);
    @(negedge clk);

    // Forced hits: 10-3=7, 10-2=8
    round(4'd15, 4'd3, 4'd15, 4'd2, 2'd1, 1'b0);
    chk("hits_ai_hp", 32'(ai_hp), 7);
    chk("hits_p_hp", 32'(p_hp), 8);
    chk("hits_last_hit", 32'(last_hit), 1);
    @(negedge clk);

    // Guaranteed misses: HP unchanged
    round(4'd0, 4'd9, 4'd0, 4'd9, 2'd2, 1'b0);
    chk("miss_ai_hp", 32'(ai_hp), 7);
    chk("miss_p_hp", 32'(p_hp), 8);
    chk("miss_last_hit", 32'(last_hit), 0);
    @(negedge clk);

    // Saturating KO: 7-15 clamps to 0, AI never attacks
    round(4'd15, 4'd15, 4'd15, 4'd9, 2'd3, 1'b0);
    go = 1'b0;
    chk("ko_ai_hp", 32'(ai_hp), 0);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("win_ignores_go", 32'(state), 5);
    chk("win_p_hp", 32'(p_hp), 8);
    chk("win_victory", 32'(victory), 1);

    // Loss path: 10 -> 5 -> 0
    do_reset();
    chk("rst2_ai_hp", 32'(ai_hp), 10);
    chk("rst2_state", 32'(state), 0);
    round(4'd0, 4'd9, 4'd15, 4'd5, 2'd0, 1'b0);
    chk("loss_r1_p_hp", 32'(p_hp), 5);
    @(negedge clk);
    round(4'd0, 4'd9, 4'd15, 4'd5, 2'd0, 1'b0);
    chk("loss_p_hp", 32'(p_hp), 0);
    chk("loss_ai_hp", 32'(ai_hp), 10);
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("lose_ignores_go", 32'(state), 6);

    // Edge during P_APPLY is dropped, held go does not retrigger
    do_reset();
    @(negedge clk);
    round(4'd15, 4'd1, 4'd15, 4'd1, 2'd2, 1'b1);
    chk("drop_ai_hp", 32'(ai_hp), 9);
    chk("drop_p_hp", 32'(p_hp), 9);
    @(negedge clk);
    chk("held_go_idle1", 32'(state), 0);
    @(negedge clk);
    chk("held_go_idle2", 32'(state), 0);
    chk("held_go_ai_hp", 32'(ai_hp), 9);
    go = 1'b0;
    @(negedge clk);

    // Mid-accuracy rolls against the reference LFSR
    round(4'd8, 4'd2, 4'd8, 4'd2, 2'd1, 1'b0);
    @(negedge clk);

    // Reset during AI_ROLL restarts everything, including the LFSR
    p_accu = 4'd15; p_dmg = 4'd4; ai_accu = 4'd15; ai_dmg = 4'd4;
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_state", 32'(state), 3);
    rst = 1'b1;
    go  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_p = 4'd10; exp_ai = 4'd10;
    chk("midrst_state", 32'(state), 0);
    chk("midrst_p_hp", 32'(p_hp), 10);
    chk("midrst_ai_hp", 32'(ai_hp), 10);
    chk("midrst_busy", 32'(busy), 0);
    round(4'd6, 4'd3, 4'd10, 4'd3, 2'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbs_turn_ctrl.md
Name: pbs_turn_ctrl

Overview:
Sequences one full battle round between the player and the AI trainer.
- Waits for a `go` edge, then runs the player attack, then the AI attack.
- Draws hit/miss and the AI move choice from an internal LFSR.
- Applies saturating HP damage and declares victory or loss.
- Owns both HP registers. The move/damage table sits outside this block in the datapath and is read combinationally via `p_dmg`/`p_accu` and `ai_dmg`/`ai_accu`.

Parameters:
- HP_W, 4, width of HP, damage and accuracy values.
- P_HP_INIT, 10, player HP loaded at reset.
- AI_HP_INIT, 10, AI HP loaded at reset.
- LFSR_SEED, 8'hA5, LFSR value at reset; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- go  in  1  level input; the rising edge starts a round
- p_move  in  2  player move select, sampled on the `go` edge
- p_dmg  in  HP_W  datapath damage for `p_move_q`
- p_accu  in  HP_W  datapath accuracy for `p_move_q`
- ai_dmg  in  HP_W  datapath damage for `ai_move`
- ai_accu  in  HP_W  datapath accuracy for `ai_move`
- p_move_q  out  2  latched player move, drives the datapath lookup
- ai_move  out  2  AI move select, drives the datapath lookup
- p_hp  out  HP_W  player HP
- ai_hp  out  HP_W  AI HP
- active_trainer  out  1  0 = player acting, 1 = AI acting
- target  out  1  1 = AI is target, 0 = player is target
- busy  out  1  round in progress
- last_hit  out  1  result of the most recent attack roll
- victory  out  1  AI HP reached 0
- loss  out  1  player HP reached 0
- state  out  3  encoded FSM state, for LEDR debug

Behaviour:
Reset values:
- `state` = IDLE, `p_hp` = P_HP_INIT, `ai_hp` = AI_HP_INIT.
- `p_move_q` = 0, `ai_move` = 0.
- `busy`, `last_hit`, `victory`, `loss`, `active_trainer`, `target` all 0.
- LFSR = LFSR_SEED, `go_q` = 0.
- `rst` overrides everything, including mid-round.

Edge detect and LFSR:
- `go_q` registers `go` every cycle; start = `go & ~go_q`.
- LFSR is 8-bit Fibonacci, taps 8,6,5,4, shift left.
- It advances every cycle that `rst` is low; `rnd` = LFSR[3:0].

Hit rule: hit = (accu == 4'hF) | (rnd < accu). Accuracy 0 never hits; 15 always hits.

Damage: new HP = (hp > dmg) ? hp - dmg : 0. Saturating, never wraps.

State encodings: IDLE=0, P_ROLL=1, P_APPLY=2, AI_ROLL=3, AI_APPLY=4, WIN=5, LOSE=6.

State transitions (one cycle each unless noted):
- IDLE: `busy` = 0. On start, latch `p_move` into `p_move_q` and go to P_ROLL. Otherwise stay.
- P_ROLL: `active_trainer` = 0, `target` = 1. Register `last_hit` from `p_accu`/`rnd` and a damage register = hit ? `p_dmg` : 0. Go to P_APPLY.
- P_APPLY: `ai_hp` ← sat-sub(`ai_hp`, damage register). Latch `ai_move` ← LFSR[5:4]. If the new `ai_hp` == 0, go to WIN; else go to AI_ROLL.
- AI_ROLL: `active_trainer` = 1, `target` = 0. Register `last_hit` from `ai_accu`/`rnd` and damage = hit ? `ai_dmg` : 0. Go to AI_APPLY.
- AI_APPLY: `p_hp` ← sat-sub. If the new `p_hp` == 0, go to LOSE; else go to IDLE.
- WIN: `victory` = 1, `busy` = 0. Terminal until `rst`; `go` is ignored.
- LOSE: `loss` = 1, `busy` = 0. Terminal until `rst`.

Timing and outputs:
- `busy` = 1 in states P_ROLL through AI_APPLY.
- Let the start edge be seen in IDLE at cycle 0. Then `ai_hp` updates visibly at cycle 3, `p_hp` at cycle 5, and IDLE is re-entered at cycle 5.
- `victory` and `loss` are never both 1. The player strikes first, so if the player KOs the AI, the AI does not attack.
- A start edge while `busy`, WIN or LOSE is dropped; it is not queued.
- `go` held high across rounds does not retrigger; a new low→high edge is required.
- `p_move` changes after the edge have no effect on the current round.
- `ai_dmg`/`ai_accu` are sampled only in AI_ROLL, one cycle after `ai_move` updates.

Test Plan:
1. Reset check: assert `rst` 1 cycle → `p_hp` = 10, `ai_hp` = 10, `state` = 0, `victory` = `loss` = 0, `busy` = 0.
2. Full round with forced hits: `p_accu` = 15, `p_dmg` = 3, `ai_accu` = 15, `ai_dmg` = 2, pulse `go` → `ai_hp` = 7 at cycle 3, `p_hp` = 8 at cycle 5, `last_hit` = 1, back to IDLE.
3. Guaranteed misses: `p_accu` = 0, `ai_accu` = 0, `p_dmg` = `ai_dmg` = 9, one round → both HPs stay 10, `last_hit` = 0.
4. Saturating KO: `p_accu` = 15, `p_dmg` = 15 on `ai_hp` = 10 → `ai_hp` = 0, WIN, `victory` = 1, `p_hp` unchanged. A further `go` edge leaves the state at WIN.
5. Loss path: `p_accu` = 0, `ai_accu` = 15, `ai_dmg` = 5 → after 2 rounds `p_hp` = 0, LOSE, `loss` = 1.
6. Dropped start and mid-round reset:
   - Toggle `go` during P_APPLY → ignored, exactly one round runs.
   - Assert `rst` in AI_ROLL → next cycle IDLE with HP 10/10 and LFSR = 8'hA5.
